// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read memory between the IF and DM ports.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed priority, DM over IF.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {GNT_IF = 1'b0, GNT_DM = 1'b1} grant_t;

  state_t           state, state_nxt;
  grant_t           grant, grant_sel;
  logic [CNT_W-1:0] lat_cnt;
  logic             req_we;

`ifdef ARB_RR_EN
  grant_t last_grant;

  // On contention the port that did not win last time gets the memory.
  always_comb begin
    grant_sel = GNT_IF;
    if (if_req && dm_req) begin
      grant_sel = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      grant_sel = GNT_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= GNT_IF;
    end else if (state == IDLE && (if_req || dm_req)) begin
      last_grant <= grant_sel;
    end
  end
`else
  always_comb begin
    grant_sel = dm_req ? GNT_DM : GNT_IF;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || dm_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes are registered so mem_en is high exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant     <= GNT_IF;
      req_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            grant  <= grant_sel;
            mem_en <= 1'b1;
            if (grant_sel == GNT_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              req_we    <= dm_we;
            end else begin
              mem_addr <= if_addr;
              req_we   <= 1'b0;
            end
          end
        end
        ISSUE: lat_cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          // Read data is on mem_rdata in the last WAIT cycle; valid follows in DONE.
          if (lat_cnt == CNT_W'(1)) begin
            if (grant == GNT_DM) begin
              dm_valid <= 1'b1;
              if (!req_we) dm_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 4) share the request inputs,
// each with its own latency-matched memory model.
module tb_mem_port_arbiter;

  localparam logic [31:0] MK   = 32'h2002_0001;
  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;

  logic        en1, we1, ifv1, dmv1, stall1;
  logic [31:0] addr1, wdata1, ifr1, dmr1, rd1;
  logic        en3, we3, ifv3, dmv3, stall3;
  logic [31:0] addr3, wdata3, ifr3, dmr3, rd3;
  logic        en4, we4, ifv4, dmv4, stall4;
  logic [31:0] addr4, wdata4, ifr4, dmr4, rd4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(ifr1), .if_valid(ifv1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dmr1),
    .dm_valid(dmv1), .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_rdata(rd1), .cpu_stall(stall1));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(ifr3), .if_valid(ifv3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dmr3),
    .dm_valid(dmv3), .mem_en(en3), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
    .mem_rdata(rd3), .cpu_stall(stall3));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(ifr4), .if_valid(ifv4),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dmr4),
    .dm_valid(dmv4), .mem_en(en4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_rdata(rd4), .cpu_stall(stall4));

  // Memory models: read data = addr ^ MK, presented MEM_LAT cycles after the mem_en cycle.
  logic [31:0] sr1 [8];
  logic [31:0] sr3 [8];
  logic [31:0] sr4 [8];
  always @(posedge clk) begin
    sr1[0] <= (en1 && !we1) ? (addr1 ^ MK) : GARB;
    sr3[0] <= (en3 && !we3) ? (addr3 ^ MK) : GARB;
    sr4[0] <= (en4 && !we4) ? (addr4 ^ MK) : GARB;
    for (int i = 1; i < 8; i++) begin
      sr1[i] <= sr1[i-1];
      sr3[i] <= sr3[i-1];
      sr4[i] <= sr4[i-1];
    end
  end
  assign rd1 = sr1[0];
  assign rd3 = sr3[2];
  assign rd4 = sr4[3];

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        en;
    logic        we;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        ifv;
    logic [31:0] ifr;
    logic        dmv;
    logic [31:0] dmr;
    logic        st;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t v(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                             logic [31:0] dd, logic en, logic we, logic [31:0] ad, logic [31:0] wd,
                             logic ifv, logic [31:0] ifr, logic dmv, logic [31:0] dmr, logic st);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
    r.en = en; r.we = we; r.ad = ad; r.wd = wd; r.ifv = ifv; r.ifr = ifr;
    r.dmv = dmv; r.dmr = dmr; r.st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ng;
    logic [31:0] order [4];
    logic        ifv_d, dmv_d;

    // IF read (0x4), DM write (0x10), simultaneous IF 0x0 / DM read 0x20 with MEM_LAT=1.
    vecs[0]  = v(0, 32'h0, 0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,         0, 32'h0,         0, 32'h0,         0);
    vecs[1]  = v(1, 32'h4, 0, 0, 32'h00, 32'h0,         0, 0, 32'h00, 32'h0,         0, 32'h0,         0, 32'h0,         1);
    vecs[2]  = v(1, 32'h4, 0, 0, 32'h00, 32'h0,         1, 0, 32'h04, 32'h0,         0, 32'h0,         0, 32'h0,         1);
    vecs[3]  = v(1, 32'h4, 0, 0, 32'h00, 32'h0,         0, 0, 32'h04, 32'h0,         0, 32'h0,         0, 32'h0,         1);
    vecs[4]  = v(1, 32'h4, 0, 0, 32'h00, 32'h0,         0, 0, 32'h04, 32'h0,         1, 32'h2002_0005, 0, 32'h0,         0);
    vecs[5]  = v(0, 32'h4, 0, 0, 32'h00, 32'h0,         0, 0, 32'h04, 32'h0,         0, 32'h2002_0005, 0, 32'h0,         0);
    vecs[6]  = v(0, 32'h4, 1, 1, 32'h10, 32'hDEADBEEF,  0, 0, 32'h04, 32'h0,         0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[7]  = v(0, 32'h4, 1, 1, 32'h10, 32'hDEADBEEF,  1, 1, 32'h10, 32'hDEADBEEF,  0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[8]  = v(0, 32'h4, 1, 1, 32'h10, 32'hDEADBEEF,  0, 0, 32'h10, 32'hDEADBEEF,  0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[9]  = v(0, 32'h4, 1, 1, 32'h10, 32'hDEADBEEF,  0, 0, 32'h10, 32'hDEADBEEF,  0, 32'h2002_0005, 1, 32'h0,         0);
    vecs[10] = v(0, 32'h4, 0, 0, 32'h10, 32'hDEADBEEF,  0, 0, 32'h10, 32'hDEADBEEF,  0, 32'h2002_0005, 0, 32'h0,         0);
    vecs[11] = v(1, 32'h0, 1, 0, 32'h20, 32'h0,         0, 0, 32'h10, 32'hDEADBEEF,  0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[12] = v(1, 32'h0, 1, 0, 32'h20, 32'h0,         1, 0, 32'h20, 32'h0,         0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[13] = v(1, 32'h0, 1, 0, 32'h20, 32'h0,         0, 0, 32'h20, 32'h0,         0, 32'h2002_0005, 0, 32'h0,         1);
    vecs[14] = v(1, 32'h0, 1, 0, 32'h20, 32'h0,         0, 0, 32'h20, 32'h0,         0, 32'h2002_0005, 1, 32'h2002_0021, 1);
    vecs[15] = v(1, 32'h0, 0, 0, 32'h20, 32'h0,         0, 0, 32'h20, 32'h0,         0, 32'h2002_0005, 0, 32'h2002_0021, 1);
    vecs[16] = v(1, 32'h0, 0, 0, 32'h20, 32'h0,         1, 0, 32'h00, 32'h0,         0, 32'h2002_0005, 0, 32'h2002_0021, 1);
    vecs[17] = v(1, 32'h0, 0, 0, 32'h20, 32'h0,         0, 0, 32'h00, 32'h0,         0, 32'h2002_0005, 0, 32'h2002_0021, 1);
    vecs[18] = v(1, 32'h0, 0, 0, 32'h20, 32'h0,         0, 0, 32'h00, 32'h0,         1, 32'h2002_0001, 0, 32'h2002_0021, 0);
    vecs[19] = v(0, 32'h0, 0, 0, 32'h20, 32'h0,         0, 0, 32'h00, 32'h0,         0, 32'h2002_0001, 0, 32'h2002_0021, 0);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      dm_req = vecs[i].dr; dm_we = vecs[i].dw; dm_addr = vecs[i].da; dm_wdata = vecs[i].dd;
      #1;
      chk($sformatf("vec%0d mem_en", i),    en1,    vecs[i].en);
      chk($sformatf("vec%0d mem_we", i),    we1,    vecs[i].we);
      chk($sformatf("vec%0d mem_addr", i),  addr1,  vecs[i].ad);
      chk($sformatf("vec%0d mem_wdata", i), wdata1, vecs[i].wd);
      chk($sformatf("vec%0d if_valid", i),  ifv1,   vecs[i].ifv);
      chk($sformatf("vec%0d if_rdata", i),  ifr1,   vecs[i].ifr);
      chk($sformatf("vec%0d dm_valid", i),  dmv1,   vecs[i].dmv);
      chk($sformatf("vec%0d dm_rdata", i),  dmr1,   vecs[i].dmr);
      chk($sformatf("vec%0d cpu_stall", i), stall1, vecs[i].st);
    end

    // Both ports re-request the cycle after their own valid pulse; grant order must alternate.
    do_reset();
    ng = 0; ifv_d = 1'b0; dmv_d = 1'b0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if_req = !ifv_d; dm_req = !dmv_d; dm_we = 1'b0;
      if_addr = 32'h100; dm_addr = 32'h200;
      #1;
      if (en1) begin
        order[ng] = addr1;
        ng++;
      end
      ifv_d = ifv1; dmv_d = dmv1;
    end
    chk("rr grant count", ng, 4);
    if (ng == 4) begin
      chk("order0 DM", order[0], 32'h200);
      chk("order1 IF", order[1], 32'h100);
      chk("order2 DM", order[2], 32'h200);
      chk("order3 IF", order[3], 32'h100);
    end

    // MEM_LAT=4: mem_en only at T+1, if_valid only at T+6.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if_req = (k <= 6); if_addr = 32'h8; dm_req = 1'b0;
      #1;
      chk($sformatf("lat4 mem_en[%0d]", k), en4, (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lat4 if_valid[%0d]", k), ifv4, (k == 6) ? 32'd1 : 32'd0);
      chk($sformatf("lat4 dm_valid[%0d]", k), dmv4, 32'd0);
      if (k == 6) chk("lat4 if_rdata", ifr4, 32'h8 ^ MK);
    end

    // MEM_LAT=3: reset during WAIT aborts the fetch; a later DM read completes at T+9.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rst_n = (k != 2);
      if_req = (k < 2); if_addr = 32'hC;
      dm_req = (k >= 4 && k <= 9); dm_we = 1'b0; dm_addr = 32'h30; dm_wdata = 32'h5555_AAAA;
      #1;
      if (k == 3) begin
        chk("rst mem_en", en3, 32'd0);
        chk("rst mem_we", we3, 32'd0);
        chk("rst mem_addr", addr3, 32'd0);
        chk("rst mem_wdata", wdata3, 32'd0);
        chk("rst if_rdata", ifr3, 32'd0);
        chk("rst dm_rdata", dmr3, 32'd0);
        chk("rst cpu_stall", stall3, 32'd0);
      end
      chk($sformatf("rst if_valid[%0d]", k), ifv3, 32'd0);
      chk($sformatf("rst dm_valid[%0d]", k), dmv3, (k == 9) ? 32'd1 : 32'd0);
      if (k == 5) chk("rst new mem_addr", addr3, 32'h30);
      if (k == 9) chk("rst new dm_rdata", dmr3, 32'h30 ^ MK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
